deint_ctrl: RTL and testbench
=============================

# deint_ctrl

RX-side sequencer for the 802.11a deinterleaver. It latches the RATE field and symbol count decoded from SIGNAL and configures the deinterleaver with a one-cycle rate-load pulse. It then gates demapped coded bits into the deinterleaver, one OFDM symbol (NCBPS bits) at a time, until the frame's last symbol is delivered. It sits between the demapper output and the deinterleaver's iRateEN/iRate/iEN/iData inputs.

## Interface
- TIMEOUT, 1024: idle-cycle limit in STREAM before abort; used only with the watchdog macro.
- iClk  in  1  system clock; all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle frame start; samples iRate/iNumSym
- iRate  in  4  802.11a RATE code (R1..R4)
- iNumSym  in  8  OFDM data symbols in frame, 1..255
- iBitValid  in  1  demapper coded-bit strobe
- iBit  in  1  demapper coded bit
- oRate  out  4  latched rate to deinterleaver iRate
- oRateEN  out  1  rate-load pulse to deinterleaver iRateEN
- oEN  out  1  bit enable to deinterleaver iEN
- oData  out  1  bit to deinterleaver iData
- oSymEnd  out  1  high with last bit of each symbol
- oBusy  out  1  high in any non-IDLE state
- oDone  out  1  one-cycle frame-complete pulse
- oErr  out  1  one-cycle error pulse (bad rate, zero symbols, timeout)

## Operation
- States: IDLE, CFG, SETTLE, STREAM, DONE.
- IDLE:
  - On iStart, latch iRate into oRate and iNumSym into the symbol register.
  - Decode NCBPS from the rate code:
    - 1101 and 1111 → 48
    - 0101 and 0111 → 96
    - 1001 and 1011 → 192
    - 0001 and 0011 → 288
  - If the rate is valid and iNumSym ≠ 0, go to CFG.
  - Otherwise pulse oErr and stay in IDLE.
- CFG: oRateEN = 1 for exactly one cycle; go to SETTLE.
- SETTLE: one cycle with no oEN; bits arriving here are dropped; go to STREAM.
- STREAM:
  - Each iBitValid cycle, register iBit to oData and assert oEN.
  - The 9-bit bit counter increments per accepted bit.
  - At count NCBPS−1:
    - Assert oSymEnd with that bit.
    - Clear the bit counter.
    - Increment the 8-bit symbol counter.
  - When the final bit of symbol iNumSym is accepted, go to DONE.
- DONE: pulse oDone; clear both counters; go to IDLE.
- iStart outside IDLE is ignored.
- Extra iBitValid after the final bit is dropped.
- oRate holds its value until the next accepted iStart.

## Timing
- Reset value of all outputs is 0, with oRate = 4'b0000. State goes to IDLE and counters clear.
- iRst mid-frame aborts in the same edge; no oDone or oErr is issued.
- iStart at edge n:
  - oBusy = 1 and oRateEN = 1 in cycle n+1.
  - SETTLE in cycle n+2.
  - First bit can be accepted in cycle n+3.
- Bit latency: iBit/iBitValid to oData/oEN is 1 cycle, registered. oSymEnd is aligned with oEN.
- oDone is high in the cycle after the final oEN beat. oBusy drops in the cycle after oDone.
- Invalid rate or zero iNumSym: oErr is high in the cycle after iStart; oBusy stays 0.
- iRst has priority over iStart in the same cycle.
- Bit counter never exceeds 287. The symbol counter wraps only via clear in DONE.

## Configuration
- DEINT_CTRL_TIMEOUT_EN defined:
  - A watchdog counter of width clog2(TIMEOUT+1) counts consecutive STREAM cycles with iBitValid = 0 and resets on each accepted bit.
  - On reaching TIMEOUT, pulse oErr, clear counters, and return to IDLE; oDone is not asserted.
- Not defined: no watchdog logic; STREAM waits indefinitely; TIMEOUT is ignored.

## Test plan
- Rate 1101, iNumSym = 2, bits every cycle → oRateEN pulse 1 cycle after iStart, 96 oEN beats, oSymEnd on beats 48 and 96, oDone once.
- Rate 0011, iNumSym = 1, iBitValid every other cycle → 288 oEN beats, single oSymEnd on beat 288, oData equals iBit delayed 1 cycle.
- Rate 0000 with iNumSym = 4, and separately rate 1001 with iNumSym = 0 → oErr pulse, oBusy stays 0, no oRateEN.
- iStart reissued mid-STREAM, and extra iBitValid after the last bit → no reconfiguration, no extra oEN, exact beat count of 192×iNumSym for rate 1001.
- iRst asserted at beat 100 of a 0101 frame → all outputs 0 next cycle; a new iStart then completes normally.
- With DEINT_CTRL_TIMEOUT_EN and TIMEOUT = 16, stall iBitValid 16 cycles mid-symbol → oErr pulse, back to IDLE, no oDone; stall of 15 cycles → frame completes.

Source files
------------

// File: rtl/deint_ctrl.sv
// Purpose : RX sequencer that configures the 802.11a deinterleaver and gates coded bits to it one OFDM symbol at a time.
// Latency : iBit/iBitValid -> oData/oEN in 1 cycle (registered); iStart -> oRateEN in 1 cycle; first bit accepted 3 cycles after iStart.
// Backpressure: none; bits arriving outside STREAM are dropped, and no ready signal goes back to the demapper.
//
// Ports:
//   iClk, iRst           clock; synchronous active-high reset
//   iStart, iRate,       frame start strobe with the RATE code and the data-symbol
//   iNumSym              count from SIGNAL, both sampled only while idle
//   iBitValid, iBit      demapper coded-bit strobe and bit
//   oRate, oRateEN       latched rate and one-cycle rate-load pulse to the deinterleaver
//   oEN, oData, oSymEnd  bit enable, bit, and last-bit-of-symbol marker to the deinterleaver
//   oBusy, oDone, oErr   frame-in-progress flag, completion pulse, error pulse
//
// Optional feature: define DEINT_CTRL_TIMEOUT_EN to add a STREAM watchdog that aborts the
// frame (oErr, no oDone) after TIMEOUT consecutive cycles without a coded bit. Without the
// macro, STREAM waits indefinitely and TIMEOUT has no effect.

module deint_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [3:0] iRate,
    input  logic [7:0] iNumSym,
    input  logic       iBitValid,
    input  logic       iBit,
    output logic [3:0] oRate,
    output logic       oRateEN,
    output logic       oEN,
    output logic       oData,
    output logic       oSymEnd,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_SETTLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t     state;
    logic [8:0] ncbps;      // coded bits per symbol for the current frame
    logic [7:0] num_sym;    // data symbols in the current frame
    logic [8:0] bit_cnt;    // bit index within the current symbol, 0..ncbps-1
    logic [7:0] sym_cnt;    // completed symbols in the current frame

    // Coded bits per OFDM symbol for each legal RATE code; 0 marks an illegal code.
    function automatic logic [8:0] rate_ncbps(input logic [3:0] rate);
        case (rate)
            4'b1101, 4'b1111: return 9'd48;   // BPSK
            4'b0101, 4'b0111: return 9'd96;   // QPSK
            4'b1001, 4'b1011: return 9'd192;  // 16-QAM
            4'b0001, 4'b0011: return 9'd288;  // 64-QAM
            default:          return 9'd0;
        endcase
    endfunction

    logic [8:0] start_ncbps;
    logic       start_ok;
    logic       last_in_sym;
    logic       last_in_frame;

    assign start_ncbps   = rate_ncbps(iRate);
    assign start_ok      = (start_ncbps != 9'd0) && (iNumSym != 8'd0);
    assign last_in_sym   = (bit_cnt == ncbps - 9'd1);
    // sym_cnt still holds the count before this symbol closes, so the final
    // symbol is the one whose index is num_sym-1.
    assign last_in_frame = last_in_sym && (sym_cnt == num_sym - 8'd1);

`ifdef DEINT_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;    // consecutive idle STREAM cycles
    logic            wd_expire;

    // The cycle being evaluated is the TIMEOUT-th idle one when the count
    // already holds TIMEOUT-1.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= S_IDLE;
            ncbps   <= 9'd0;
            num_sym <= 8'd0;
            bit_cnt <= 9'd0;
            sym_cnt <= 8'd0;
            oRate   <= 4'b0000;
            oRateEN <= 1'b0;
            oEN     <= 1'b0;
            oData   <= 1'b0;
            oSymEnd <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
`ifdef DEINT_CTRL_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
        end else begin
            // Pulse outputs default low; each state raises only what it owns.
            oRateEN <= 1'b0;
            oEN     <= 1'b0;
            oSymEnd <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;

            case (state)
                S_IDLE: begin
                    oBusy   <= 1'b0;
                    bit_cnt <= 9'd0;
                    sym_cnt <= 8'd0;
`ifdef DEINT_CTRL_TIMEOUT_EN
                    wd_cnt  <= '0;
`endif
                    if (iStart) begin
                        // The rate is latched even for a rejected start so oRate
                        // always reflects the last start seen while idle.
                        oRate   <= iRate;
                        ncbps   <= start_ncbps;
                        num_sym <= iNumSym;
                        if (start_ok) begin
                            oRateEN <= 1'b1;
                            oBusy   <= 1'b1;
                            state   <= S_CFG;
                        end else begin
                            oErr    <= 1'b1;
                        end
                    end
                end

                S_CFG: begin
                    // oRateEN was raised on entry and drops here by default.
                    state <= S_SETTLE;
                end

                S_SETTLE: begin
                    // Gives the deinterleaver one cycle to apply the new rate;
                    // any bit offered now is discarded.
                    state <= S_STREAM;
                end

                S_STREAM: begin
                    if (iBitValid) begin
                        oEN   <= 1'b1;
                        oData <= iBit;
`ifdef DEINT_CTRL_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                        if (last_in_sym) begin
                            oSymEnd <= 1'b1;
                            bit_cnt <= 9'd0;
                            sym_cnt <= sym_cnt + 8'd1;
                            if (last_in_frame) begin
                                state <= S_DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
`ifdef DEINT_CTRL_TIMEOUT_EN
                    else if (wd_expire) begin
                        // Abort: report the error and free the block; the frame
                        // never produces oDone.
                        oErr    <= 1'b1;
                        oBusy   <= 1'b0;
                        bit_cnt <= 9'd0;
                        sym_cnt <= 8'd0;
                        wd_cnt  <= '0;
                        state   <= S_IDLE;
                    end else begin
                        wd_cnt  <= wd_cnt + WD_W'(1);
                    end
`endif
                end

                S_DONE: begin
                    // oBusy stays high through the oDone cycle and drops in IDLE.
                    oDone   <= 1'b1;
                    bit_cnt <= 9'd0;
                    sym_cnt <= 8'd0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deint_ctrl.sv
`timescale 1ns/1ps

module tb_deint_ctrl;

    localparam int TB_TIMEOUT = 16;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iStart;
    logic [3:0] iRate;
    logic [7:0] iNumSym;
    logic       iBitValid;
    logic       iBit;
    logic [3:0] oRate;
    logic       oRateEN;
    logic       oEN;
    logic       oData;
    logic       oSymEnd;
    logic       oBusy;
    logic       oDone;
    logic       oErr;

    deint_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iRate     (iRate),
        .iNumSym   (iNumSym),
        .iBitValid (iBitValid),
        .iBit      (iBit),
        .oRate     (oRate),
        .oRateEN   (oRateEN),
        .oEN       (oEN),
        .oData     (oData),
        .oSymEnd   (oSymEnd),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oErr      (oErr)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 802.11a coded bits per OFDM symbol indexed by RATE code; 0 = illegal code.
    int ncbps_tbl [16] = '{0, 288, 0, 288, 0, 96, 0, 96, 0, 192, 0, 192, 0, 48, 0, 48};

    // Frame phase: 0 idle, 1 config/settle countdown, 2 delivering bits, 3 completion.
    int   m_mode  = 0;
    int   m_pre   = 0;
    int   m_beats = 0;
    int   m_total = 0;
    int   m_ncb   = 0;
    int   m_idle  = 0;
    bit   model_live = 1'b0;
    logic [3:0] e_rate   = 4'b0000;
    logic       e_rateen = 1'b0;
    logic       e_en     = 1'b0;
    logic       e_data   = 1'b0;
    logic       e_symend = 1'b0;
    logic       e_busy   = 1'b0;
    logic       e_done   = 1'b0;
    logic       e_err    = 1'b0;

    always @(posedge iClk) begin
        e_rateen = 1'b0;
        e_en     = 1'b0;
        e_symend = 1'b0;
        e_done   = 1'b0;
        e_err    = 1'b0;
        if (iRst === 1'b1) begin
            m_mode     = 0;
            e_rate     = 4'b0000;
            e_busy     = 1'b0;
            e_data     = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            case (m_mode)
                0: begin
                    e_busy = 1'b0;
                    if (iStart) begin
                        e_rate = iRate;
                        m_ncb  = ncbps_tbl[iRate];
                        if (m_ncb == 0 || iNumSym == 8'd0) begin
                            e_err = 1'b1;
                        end else begin
                            e_busy   = 1'b1;
                            e_rateen = 1'b1;
                            m_total  = m_ncb * int'(iNumSym);
                            m_beats  = 0;
                            m_idle   = 0;
                            m_pre    = 2;
                            m_mode   = 1;
                        end
                    end
                end
                1: begin
                    m_pre--;
                    if (m_pre == 0) m_mode = 2;
                end
                2: begin
                    if (iBitValid) begin
                        m_beats++;
                        e_en     = 1'b1;
                        e_data   = iBit;
                        e_symend = ((m_beats % m_ncb) == 0);
                        m_idle   = 0;
                        if (m_beats == m_total) m_mode = 3;
                    end else begin
                        m_idle++;
`ifdef DEINT_CTRL_TIMEOUT_EN
                        if (m_idle == TB_TIMEOUT) begin
                            e_err  = 1'b1;
                            e_busy = 1'b0;
                            m_mode = 0;
                        end
`endif
                    end
                end
                default: begin
                    e_done = 1'b1;
                    m_mode = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int cnt_en = 0, cnt_symend = 0, cnt_done = 0, cnt_err = 0, cnt_rateen = 0, cnt_busy = 0;

    always @(negedge iClk) begin
        if (model_live) begin
            chk("oRate",   32'(oRate),   32'(e_rate));
            chk("oRateEN", 32'(oRateEN), 32'(e_rateen));
            chk("oEN",     32'(oEN),     32'(e_en));
            chk("oData",   32'(oData),   32'(e_data));
            chk("oSymEnd", 32'(oSymEnd), 32'(e_symend));
            chk("oBusy",   32'(oBusy),   32'(e_busy));
            chk("oDone",   32'(oDone),   32'(e_done));
            chk("oErr",    32'(oErr),    32'(e_err));
            if (oEN === 1'b1)     cnt_en++;
            if (oSymEnd === 1'b1) cnt_symend++;
            if (oDone === 1'b1)   cnt_done++;
            if (oErr === 1'b1)    cnt_err++;
            if (oRateEN === 1'b1) cnt_rateen++;
            if (oBusy === 1'b1)   cnt_busy++;
        end
    end

    // ---------------- stimulus ----------------
    int s_en, s_symend, s_done, s_err, s_rateen, s_busy;

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic snap();
        s_en = cnt_en; s_symend = cnt_symend; s_done = cnt_done;
        s_err = cnt_err; s_rateen = cnt_rateen; s_busy = cnt_busy;
    endtask

    // Hand-computed per-frame expectations.
    task automatic frame_check(input string tag, input int en, input int se, input int dn,
                               input int er, input int re);
        chk({tag, "_beats"},  32'(cnt_en - s_en),         32'(en));
        chk({tag, "_symend"}, 32'(cnt_symend - s_symend), 32'(se));
        chk({tag, "_done"},   32'(cnt_done - s_done),     32'(dn));
        chk({tag, "_err"},    32'(cnt_err - s_err),       32'(er));
        chk({tag, "_rateen"}, 32'(cnt_rateen - s_rateen), 32'(re));
    endtask

    task automatic do_start(input logic [3:0] r, input logic [7:0] n);
        iStart  = 1'b1;
        iRate   = r;
        iNumSym = n;
        tick();
        iStart  = 1'b0;
        iRate   = 4'($urandom);
        iNumSym = 8'($urandom);
    endtask

    // mode: 0 bit every cycle, 1 every other cycle, 2 random bits with stray starts, 3 no bits
    task automatic drive(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            iStart = 1'b0;
            case (mode)
                0: iBitValid = 1'b1;
                1: iBitValid = ((i % 2) == 0);
                2: begin
                    iBitValid = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 63) == 0) begin
                        iStart  = 1'b1;
                        iRate   = 4'($urandom);
                        iNumSym = 8'($urandom_range(0, 2));
                    end
                end
                default: iBitValid = 1'b0;
            endcase
            iBit = 1'($urandom_range(0, 1));
            tick();
        end
        iBitValid = 1'b0;
        iStart    = 1'b0;
    endtask

    initial begin
        iRst = 1'b1; iStart = 1'b0; iRate = 4'b0000; iNumSym = 8'd0;
        iBitValid = 1'b0; iBit = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({oRate, oRateEN, oEN, oData, oSymEnd, oBusy, oDone, oErr}), 32'd0);
        iRst = 1'b0;
        tick();

        // Rate 1101, 2 symbols, bit every cycle.
        snap();
        do_start(4'b1101, 8'd2);
        chk("t1_busy_after_start", 32'(oBusy), 32'd1);
        drive(110, 0);
        frame_check("t1", 96, 2, 1, 0, 1);

        // Rate 0011, 1 symbol, bit every other cycle.
        snap();
        do_start(4'b0011, 8'd1);
        drive(600, 1);
        frame_check("t2", 288, 1, 1, 0, 1);

        // Illegal rate, then zero symbols.
        snap();
        do_start(4'b0000, 8'd4);
        drive(10, 0);
        frame_check("t3a", 0, 0, 0, 1, 0);
        chk("t3a_busy_cycles", 32'(cnt_busy - s_busy), 32'd0);
        snap();
        do_start(4'b1001, 8'd0);
        drive(10, 0);
        frame_check("t3b", 0, 0, 0, 1, 0);
        chk("t3b_busy_cycles", 32'(cnt_busy - s_busy), 32'd0);

        // Rate 1001, 2 symbols; restart attempt mid-stream and surplus bits.
        snap();
        do_start(4'b1001, 8'd2);
        drive(100, 0);
        do_start(4'b0101, 8'd3);
        drive(400, 0);
        frame_check("t4", 384, 2, 1, 0, 1);
        chk("t4_rate_held", 32'(oRate), 32'(4'b1001));

        // Reset at beat 100 of a 0101 frame, then a clean frame.
        snap();
        do_start(4'b0101, 8'd3);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 400 && !hit; i++) begin
                iBitValid = 1'b1;
                iBit = 1'($urandom_range(0, 1));
                tick();
                if (cnt_en - s_en >= 100) hit = 1'b1;
            end
            chk("t5_reached_beat100", 32'(hit), 32'd1);
        end
        iBitValid = 1'b1;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        iBitValid = 1'b0;
        chk("t5_outputs_after_rst", 32'({oRate, oRateEN, oEN, oData, oSymEnd, oBusy, oDone, oErr}), 32'd0);
        chk("t5_no_done_err", 32'((cnt_done - s_done) + (cnt_err - s_err)), 32'd0);
        tick();
        snap();
        do_start(4'b0101, 8'd1);
        drive(110, 0);
        frame_check("t5b", 96, 1, 1, 0, 1);

`ifdef DEINT_CTRL_TIMEOUT_EN
        // Stall of exactly TIMEOUT idle cycles aborts the frame.
        snap();
        do_start(4'b1101, 8'd2);
        drive(22, 0);
        drive(TB_TIMEOUT, 3);
        drive(100, 0);
        frame_check("wd16", 20, 0, 0, 1, 1);
        // One cycle shorter completes normally.
        snap();
        do_start(4'b1101, 8'd2);
        drive(22, 0);
        drive(TB_TIMEOUT - 1, 3);
        drive(100, 0);
        frame_check("wd15", 96, 2, 1, 0, 1);
`endif

        // Randomized frames with random bit gaps and stray starts.
        for (int f = 0; f < 6; f++) begin
            logic [3:0] r;
            logic [7:0] n;
            r = 4'($urandom);
            n = 8'($urandom_range(0, 3));
            do_start(r, n);
            drive(ncbps_tbl[r] * int'(n) * 3 + 30, 2);
            drive(5, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL global_timeout: simulation did not finish, expected completion before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
